// File: rtl/calc_pkg.sv
// Shared encodings for the calculator request port: commands, response codes,
// FSM state constants and the buffered request entry layout.
package calc_pkg;

  localparam logic [3:0] CMD_NOP = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_ERR  = 2'd2;
  localparam logic [1:0] RSP_TMO  = 2'd3;

  typedef logic [1:0] calc_state_t;
  localparam calc_state_t ST_IDLE   = 2'd0;
  localparam calc_state_t ST_ISSUE1 = 2'd1;
  localparam calc_state_t ST_ISSUE2 = 2'd2;
  localparam calc_state_t ST_WAIT   = 2'd3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } calc_req_t;

  localparam int REQ_W = $bits(calc_req_t);

endpackage

// File: rtl/calc_req_fifo.sv
// Generic show-ahead FIFO: head visible combinationally, one-cycle write-to-read.
// Full blocks pushes, empty blocks pops; simultaneous push/pop keeps the count.
module calc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dat   = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/calc_req_port.sv
// Buffers calculator requests and issues them one at a time (cmd/op1, then op2), then waits
// for a response or timeout; push to ISSUE1 is two cycles, in_ready drops when the buffer is full.
module calc_req_port
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        busy,
  output logic        timeout_err,
  output logic        protocol_err
);

  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  calc_state_t r_state;
  logic [3:0]  r_req_cmd;
  logic [31:0] r_req_data;
  logic [3:0]  r_cur_cmd;
  logic [31:0] r_cur_op2;
  logic [7:0]  r_wait_cnt;
  logic        r_rsp_valid;
  logic [1:0]  r_rsp_code;
  logic [31:0] r_rsp_data;
  logic [3:0]  r_rsp_cmd;
  logic        r_timeout_err;
  logic        r_protocol_err;

  calc_req_t   w_in_req;
  calc_req_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_resp_any;

  assign w_in_req.cmd = in_cmd;
  assign w_in_req.op1 = in_op1;
  assign w_in_req.op2 = in_op2;

  assign in_ready   = ~w_full & ~reset;
  assign w_push     = in_valid & in_ready;
  // NOP heads are popped in IDLE too; they are simply never issued.
  assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
  assign w_resp_any = (out_resp != RSP_NONE);

  calc_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .i_clk   (c_clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_dat   (w_in_req),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_req_cmd      <= '0;
      r_req_data     <= '0;
      r_cur_cmd      <= '0;
      r_cur_op2      <= '0;
      r_wait_cnt     <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_code     <= '0;
      r_rsp_data     <= '0;
      r_rsp_cmd      <= '0;
      r_timeout_err  <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_resp_any && (r_state != ST_WAIT)) begin
        r_protocol_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && (w_head.cmd != CMD_NOP)) begin
            r_state    <= ST_ISSUE1;
            r_cur_cmd  <= w_head.cmd;
            r_cur_op2  <= w_head.op2;
            r_req_cmd  <= w_head.cmd;
            r_req_data <= w_head.op1;
          end
        end
        ST_ISSUE1: begin
          r_state    <= ST_ISSUE2;
          r_req_cmd  <= '0;
          r_req_data <= r_cur_op2;
        end
        ST_ISSUE2: begin
          r_state    <= ST_WAIT;
          r_req_data <= '0;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          // A response on the last allowed cycle wins over the timeout.
          if (w_resp_any) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_code  <= out_resp;
            r_rsp_data  <= out_data;
            r_rsp_cmd   <= r_cur_cmd;
          end else if (r_wait_cnt == LP_TMO_LAST) begin
            r_state       <= ST_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_code    <= RSP_TMO;
            r_rsp_data    <= '0;
            r_rsp_cmd     <= r_cur_cmd;
            r_timeout_err <= 1'b1;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_cmd_in   = r_req_cmd;
  assign req_data_in  = r_req_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_code     = r_rsp_code;
  assign rsp_data     = r_rsp_data;
  assign rsp_cmd      = r_rsp_cmd;
  assign busy         = (r_state != ST_IDLE);
  assign timeout_err  = r_timeout_err;
  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_calc_req_port.sv
// Scoreboard bench for calc_req_port: pushes expectations at request time, a scripted
// calculator responder answers in WAIT, and negedge monitors compare port and response traffic.
module tb_calc_req_port;
  import calc_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic        busy;
  logic        timeout_err;
  logic        protocol_err;

  always #5 c_clk = ~c_clk;

  calc_req_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .req_cmd_in   (req_cmd_in),
    .req_data_in  (req_data_in),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .rsp_valid    (rsp_valid),
    .rsp_code     (rsp_code),
    .rsp_data     (rsp_data),
    .rsp_cmd      (rsp_cmd),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err)
  );

  typedef struct {
    int          delay;
    logic [1:0]  code;
    logic [31:0] data;
  } plan_t;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } iss_t;
  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] data;
    logic [3:0]  cmd;
  } rsp_t;

  plan_t plan_q[$];
  iss_t  iss_q[$];
  rsp_t  rsp_q[$];
  int    cyc_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int last_rsp_cyc = -10;
  int last_iss_cyc = -10;
  bit b2b = 1'b0;
  logic [1:0]  last_code = '0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_cmd  = '0;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Calculator behaviour used to produce the result the responder returns.
  function automatic logic [31:0] calc_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_SHL: return a << b[4:0];
      CMD_SHR: return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #1;
    end
  endtask

  // Offer one request; on acceptance record its issue, response plan and expected completion.
  task automatic push_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input logic [1:0] code, output int acc_cyc);
    int    n;
    plan_t p;
    iss_t  e;
    rsp_t  r;
    n = 0;
    in_valid = 1'b1;
    in_cmd = c;
    in_op1 = a;
    in_op2 = b;
    while (!in_ready && n < 300) begin
      tick(1);
      n++;
    end
    chk("push_accepted", 32'(in_ready), 32'd1);
    acc_cyc = cyc;
    if (in_ready && c != CMD_NOP) begin
      p.delay = delay;
      p.code  = code;
      p.data  = calc_result(c, a, b);
      plan_q.push_back(p);
      e.cmd = c;
      e.op1 = a;
      e.op2 = b;
      iss_q.push_back(e);
      if (delay < TMO) r = {code, p.data, c};
      else             r = {2'b11, 32'h0, c};
      rsp_q.push_back(r);
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || iss_q.size() != 0 || busy) && n < 1000) begin
      tick(1);
      n++;
    end
    chk("drain_done", 32'(rsp_q.size() == 0 && iss_q.size() == 0 && !busy), 32'd1);
    tick(2);
  endtask

  // Calculator side: answer each issued request after its planned number of WAIT cycles.
  initial begin
    plan_t p;
    int    k;
    forever begin
      @(negedge c_clk);
      if (!reset && req_cmd_in != 4'h0 && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        k = cyc;
        if (p.delay < TMO) begin
          cyc_q.push_back(k + 3 + p.delay);
          repeat (p.delay + 2) @(posedge c_clk);
          #1;
          out_resp = p.code;
          out_data = p.data;
          @(posedge c_clk);
          #1;
          out_resp = 2'd0;
          out_data = 32'd0;
        end else begin
          cyc_q.push_back(k + 2 + TMO);
        end
      end
    end
  end

  // Port monitor: ISSUE1 carries cmd/op1, the next cycle op2 with cmd 0, otherwise all zero.
  logic        i2_pend = 1'b0;
  logic [31:0] i2_op2 = '0;
  always @(negedge c_clk) begin
    iss_t e;
    if (reset) begin
      i2_pend = 1'b0;
    end else if (i2_pend) begin
      chk("issue2_cmd", 32'(req_cmd_in), 32'd0);
      chk("issue2_data", req_data_in, i2_op2);
      i2_pend = 1'b0;
    end else if (req_cmd_in != 4'h0) begin
      chk("issue_expected", 32'(iss_q.size() != 0), 32'd1);
      if (iss_q.size() != 0) begin
        e = iss_q.pop_front();
        chk("issue1_cmd", 32'(req_cmd_in), 32'(e.cmd));
        chk("issue1_data", req_data_in, e.op1);
        i2_op2 = e.op2;
        i2_pend = 1'b1;
        if (b2b) chk("issue_after_rsp", 32'(cyc), 32'(last_rsp_cyc + 1));
      end
      last_iss_cyc = cyc;
    end else begin
      chk("idle_port_data", req_data_in, 32'd0);
    end
  end

  // Response monitor: completions in order, on the expected cycle, holding between pulses.
  always @(negedge c_clk) begin
    rsp_t r;
    int   ec;
    if (!reset) begin
      if (rsp_valid) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk("rsp_code", 32'(rsp_code), 32'(r.code));
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_cmd", 32'(rsp_cmd), 32'(r.cmd));
          last_code = r.code;
          last_data = r.data;
          last_cmd  = r.cmd;
        end
        if (cyc_q.size() != 0) begin
          ec = cyc_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(ec));
        end
        last_rsp_cyc = cyc;
      end else begin
        chk("hold_code", 32'(rsp_code), 32'(last_code));
        chk("hold_data", rsp_data, last_data);
        chk("hold_cmd", 32'(rsp_cmd), 32'(last_cmd));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_cmd"}, 32'(rsp_cmd), 32'd0);
    chk({tag, "_req_cmd"}, 32'(req_cmd_in), 32'd0);
    chk({tag, "_req_data"}, req_data_in, 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_protocol_err"}, 32'(protocol_err), 32'd0);
  endtask

  initial begin
    int pc;
    logic [3:0] cmds [5];
    cmds[0] = CMD_NOP; cmds[1] = CMD_ADD; cmds[2] = CMD_SUB; cmds[3] = CMD_SHL; cmds[4] = CMD_SHR;

    reset = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    tick(1);

    // Single ADD 5/7 answered OK two WAIT cycles in.
    push_req(CMD_ADD, 32'd5, 32'd7, 2, RSP_OK, pc);
    drain();
    chk("push_to_issue1_latency", 32'(last_iss_cyc), 32'(pc + 2));
    chk("add_rsp_data", rsp_data, 32'd12);

    // One request in WAIT, then fill the buffer and try one more.
    push_req(CMD_ADD, 32'd100, 32'd1, 10, RSP_OK, pc);
    for (int i = 0; i < 4; i++) begin
      push_req(CMD_SUB, 32'(50 + 10 * i), 32'(i), i % 3, RSP_OK, pc);
    end
    chk("in_ready_when_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_cmd = CMD_SHR;
    in_op1 = 32'hFFFF_0000;
    in_op2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      chk("fifth_push_refused", 32'(in_ready), 32'd0);
      tick(1);
    end
    in_valid = 1'b0;
    b2b = 1'b1;
    drain();
    b2b = 1'b0;

    // Response on the last allowed WAIT cycle, then a full timeout.
    chk("timeout_err_clear", 32'(timeout_err), 32'd0);
    push_req(CMD_ADD, 32'd3, 32'd4, TMO - 1, RSP_ERR, pc);
    drain();
    chk("late_rsp_no_timeout", 32'(timeout_err), 32'd0);
    push_req(CMD_SUB, 32'd9, 32'd4, 100, RSP_OK, pc);
    drain();
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    tick(5);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // NOP is discarded silently; the following SHL completes.
    push_req(CMD_NOP, 32'hDEAD, 32'hBEEF, 0, RSP_OK, pc);
    push_req(CMD_SHL, 32'd1, 32'd3, 0, RSP_OK, pc);
    drain();
    chk("shl_rsp_data", rsp_data, 32'd8);
    chk("shl_rsp_cmd", 32'(rsp_cmd), 32'(CMD_SHL));

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      push_req(cmds[$urandom_range(0, 4)], $urandom, $urandom,
               int'($urandom_range(0, TMO + 3)), 2'($urandom_range(1, 3)), pc);
      tick(int'($urandom_range(0, 3)));
    end
    drain();
    chk("protocol_err_clean", 32'(protocol_err), 32'd0);

    // Reset while a request waits and two more are buffered.
    push_req(CMD_ADD, 32'd1, 32'd2, 200, RSP_OK, pc);
    push_req(CMD_SUB, 32'd7, 32'd1, 0, RSP_OK, pc);
    push_req(CMD_SHR, 32'd64, 32'd2, 0, RSP_OK, pc);
    tick(4);
    chk("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    plan_q.delete();
    iss_q.delete();
    rsp_q.delete();
    cyc_q.delete();
    last_code = '0;
    last_data = '0;
    last_cmd  = '0;
    tick(2);
    check_all_zero("midreset");
    reset = 1'b0;
    #1;
    chk("in_ready_after_midreset", 32'(in_ready), 32'd1);
    tick(12);
    chk("idle_after_flush", 32'(busy), 32'd0);
    out_resp = RSP_OK;
    tick(1);
    out_resp = RSP_NONE;
    tick(1);
    chk("protocol_err_set", 32'(protocol_err), 32'd1);
    chk("protocol_no_rsp", 32'(rsp_valid), 32'd0);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
